// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: issues one imem request at a time, buffers the returned
// instruction toward decode and squashes wrong-path fetches on an execute redirect.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_taken,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StKill,
        StHalt
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_plus4_q;
    logic [31:0] instr_buf_q;
    logic        misaligned_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            pc_q             <= RESET_PC;
            fetch_pc_q       <= 32'h0;
            fetch_pc_plus4_q <= 32'h0;
            instr_buf_q      <= 32'h0;
            misaligned_q     <= 1'b0;
        end else if (br_taken && (state_q != StHalt)) begin
            // A redirect overrides every other event; a misaligned target freezes the unit.
            if (new_pc[1:0] != 2'b00) begin
                misaligned_q <= 1'b1;
                state_q      <= StHalt;
            end else begin
                pc_q <= new_pc;
                unique case (state_q)
                    StIdle, StHold: state_q <= StReq;
                    StReq:          state_q <= imem_gnt ? StKill : StReq;
                    StWait, StKill: state_q <= imem_rvalid ? StReq : StKill;
                    default:        state_q <= state_q;
                endcase
            end
        end else begin
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (imem_gnt) begin
                        fetch_pc_q       <= pc_q;
                        // Kept as a register so the output is 0 out of reset, not 4.
                        fetch_pc_plus4_q <= pc_q + 32'd4;
                        pc_q             <= pc_q + 32'd4;
                        state_q          <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr_buf_q <= imem_rdata;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (if_ready) begin
                        state_q <= StReq;
                    end
                end
                StKill: begin
                    if (imem_rvalid) begin
                        state_q <= StReq;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= state_q;
            endcase
        end
    end

    always_comb begin
        imem_req    = (state_q == StReq);
        imem_addr   = (state_q == StReq) ? pc_q : 32'h0;
        if_valid    = (state_q == StHold);
        if_pc       = fetch_pc_q;
        if_pc_plus4 = fetch_pc_plus4_q;
        if_instr    = instr_buf_q;
        flush       = br_taken && (state_q != StHalt);
        misaligned  = misaligned_q;
    end

endmodule
